// File: rtl/temp_sense_pkg.sv
// temp_sense_pkg: shared types and constants for the temperature-sense controller.
// Holds the controller state enum, the sensor code offset, the clamp ceiling
// and the BCD digit width used by the converter and the result bus.
package temp_sense_pkg;

  localparam int TSD_OFFSET  = 128;  // ADC code that corresponds to 0 degrees C
  localparam int TEMP_MAX    = 99;   // highest displayable temperature
  localparam int BCD_DIGIT_W = 4;    // bits per BCD digit

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_CONVERT = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_CALC    = 3'd4,
    ST_BCD     = 3'd5,
    ST_PRESENT = 3'd6,
    ST_WAIT    = 3'd7
  } state_e;

endpackage

// File: rtl/temp_sense_ctrl_if.sv
// temp_sense_ctrl_if: ADC-side and display-side signals of the controller.
// ADC side: ts_out/ts_done in, ts_enable/ts_clear out.
// Display side: temp_valid/temp_ready handshake carrying raw code, BCD and clamp flags.
interface temp_sense_ctrl_if;
  logic [7:0] ts_out;
  logic       ts_done;
  logic       ts_enable;
  logic       ts_clear;
  logic       temp_valid;
  logic       temp_ready;
  logic [7:0] temp_raw;
  logic [7:0] temp_bcd;
  logic       temp_under;
  logic       temp_over;

  // master: the controller
  modport master (
    input  ts_out, ts_done, temp_ready,
    output ts_enable, ts_clear, temp_valid, temp_raw, temp_bcd, temp_under, temp_over
  );

  // slave: ADC model plus display stage
  modport slave (
    output ts_out, ts_done, temp_ready,
    input  ts_enable, ts_clear, temp_valid, temp_raw, temp_bcd, temp_under, temp_over
  );
endinterface

// File: rtl/temp_sense_ctrl_bcd.sv
// bin_to_bcd99: sequential 0..99 binary to two-digit BCD, one subtract-10 per cycle.
// Ports: clk_i, rst_n_i, start_i/bin_i load a value; done_o is high while bcd_o is final.
// done_o asserts the cycle the remainder drops below 10 (at most 9 subtractions).
module bin_to_bcd99 import temp_sense_pkg::*; (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       start_i,
  input  logic [6:0]                 bin_i,
  output logic                       done_o,
  output logic [2*BCD_DIGIT_W-1:0]   bcd_o
);

  logic                   busy_q, busy_d;
  logic [6:0]             rem_q, rem_d;
  logic [BCD_DIGIT_W-1:0] tens_q, tens_d;

  always_comb begin
    busy_d = busy_q;
    rem_d  = rem_q;
    tens_d = tens_q;
    if (start_i) begin
      busy_d = 1'b1;
      rem_d  = bin_i;
      tens_d = '0;
    end else if (busy_q) begin
      if (rem_q >= 7'd10) begin
        rem_d  = rem_q - 7'd10;
        tens_d = tens_q + BCD_DIGIT_W'(1);
      end else begin
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      busy_q <= 1'b0;
      rem_q  <= '0;
      tens_q <= '0;
    end else begin
      busy_q <= busy_d;
      rem_q  <= rem_d;
      tens_q <= tens_d;
    end
  end

  assign done_o = busy_q && (rem_q < 7'd10);
  assign bcd_o  = {tens_q, rem_q[BCD_DIGIT_W-1:0]};

endmodule

// File: rtl/temp_sense_ctrl.sv
// temp_sense_ctrl: periodic temperature sampling -> clamp -> BCD -> valid/ready result.
// Ports: clk_50mhz, rst_50mhz_n (async assert, sync release), start level, bus (ADC +
// display), timeout_err sticky. Result held stable in PRESENT until temp_ready.
module temp_sense_ctrl import temp_sense_pkg::*; #(
  parameter int unsigned SAMPLE_PERIOD = 50000000,
  parameter int unsigned CONV_TIMEOUT  = 1000000,
  parameter int unsigned CLEAR_CYCLES  = 4
) (
  input  logic                  clk_50mhz,
  input  logic                  rst_50mhz_n,
  input  logic                  start,
  temp_sense_ctrl_if.master     bus,
  output logic                  timeout_err
);

  // Reset asserts immediately, releases two clocks after the pin goes high.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge clk_50mhz or negedge rst_50mhz_n) begin
    if (!rst_50mhz_n) rst_sync_q <= 2'b00;
    else              rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  // ts_done comes from the ADC clock domain.
  logic [1:0] done_sync_q;
  logic       done_s;

  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) done_sync_q <= 2'b00;
    else        done_sync_q <= {done_sync_q[0], bus.ts_done};
  end
  assign done_s = done_sync_q[1];

  state_e      state_q, state_d;
  logic [31:0] period_q, period_d;  // cycles left until the next sample may start
  logic [31:0] cyc_q, cyc_d;        // per-state cycle count for CLEAR and CONVERT
  logic [7:0]  raw_q, raw_d;
  logic [7:0]  bcd_q, bcd_d;
  logic        under_q, under_d;
  logic        over_q, over_d;
  logic        terr_q, terr_d;

  logic signed [8:0] t;
  logic [6:0]        bin_clamp;
  logic              bcd_start;
  logic              bcd_done;
  logic [7:0]        bcd_res;

  always_comb begin
    t = $signed({1'b0, raw_q}) - $signed(9'(TSD_OFFSET));
    if (t[8])                             bin_clamp = 7'd0;
    else if (t > $signed(9'(TEMP_MAX)))   bin_clamp = 7'(TEMP_MAX);
    else                                  bin_clamp = t[6:0];
  end

  always_comb begin
    state_d   = state_q;
    period_d  = period_q;
    cyc_d     = cyc_q;
    raw_d     = raw_q;
    bcd_d     = bcd_q;
    under_d   = under_q;
    over_d    = over_q;
    terr_d    = terr_q;
    bcd_start = 1'b0;

    if (state_q != ST_IDLE && period_q != 32'd0) period_d = period_q - 32'd1;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_CLEAR;
          period_d = SAMPLE_PERIOD - 32'd1;
          cyc_d    = 32'd0;
        end
      end
      ST_CLEAR: begin
        if (cyc_q == CLEAR_CYCLES - 32'd1) begin
          state_d = ST_CONVERT;
          cyc_d   = 32'd0;
        end else begin
          cyc_d = cyc_q + 32'd1;
        end
      end
      ST_CONVERT: begin
        // A done arriving on the timeout cycle still counts as a good conversion.
        if (done_s) begin
          state_d = ST_CAPTURE;
        end else if (cyc_q == CONV_TIMEOUT - 32'd1) begin
          terr_d  = 1'b1;
          state_d = ST_WAIT;
        end else begin
          cyc_d = cyc_q + 32'd1;
        end
      end
      ST_CAPTURE: begin
        raw_d   = bus.ts_out;
        state_d = ST_CALC;
      end
      ST_CALC: begin
        under_d   = t[8];
        over_d    = !t[8] && (t > $signed(9'(TEMP_MAX)));
        bcd_start = 1'b1;
        state_d   = ST_BCD;
      end
      ST_BCD: begin
        if (bcd_done) begin
          bcd_d   = bcd_res;
          state_d = ST_PRESENT;
        end
      end
      ST_PRESENT, ST_WAIT: begin
        // A late handshake with the period already expired skips WAIT entirely.
        if ((state_q == ST_PRESENT && bus.temp_ready && period_q == 32'd0) ||
            (state_q == ST_WAIT && period_q == 32'd0)) begin
          if (start) begin
            state_d  = ST_CLEAR;
            period_d = SAMPLE_PERIOD - 32'd1;
            cyc_d    = 32'd0;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (state_q == ST_PRESENT && bus.temp_ready) begin
          state_d = ST_WAIT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      period_q <= '0;
      cyc_q    <= '0;
      raw_q    <= '0;
      bcd_q    <= '0;
      under_q  <= 1'b0;
      over_q   <= 1'b0;
      terr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      period_q <= period_d;
      cyc_q    <= cyc_d;
      raw_q    <= raw_d;
      bcd_q    <= bcd_d;
      under_q  <= under_d;
      over_q   <= over_d;
      terr_q   <= terr_d;
    end
  end

  bin_to_bcd99 u_bcd (
    .clk_i   (clk_50mhz),
    .rst_n_i (rst_n),
    .start_i (bcd_start),
    .bin_i   (bin_clamp),
    .done_o  (bcd_done),
    .bcd_o   (bcd_res)
  );

  assign bus.ts_clear   = (state_q == ST_CLEAR);
  assign bus.ts_enable  = (state_q == ST_CONVERT);
  assign bus.temp_valid = (state_q == ST_PRESENT);
  assign bus.temp_raw   = raw_q;
  assign bus.temp_bcd   = bcd_q;
  assign bus.temp_under = under_q;
  assign bus.temp_over  = over_q;
  assign timeout_err    = terr_q;

endmodule
